// File: rtl/sobel_edge_packer.sv
// Thresholds a Sobel gradient stream into 1-bit edge flags, packs them LSB-first
// into per-row bytes, and reports the edge-pixel total of each completed frame.
module sobel_edge_packer #(
    parameter int WIDTH_P  = 10,
    parameter int HEIGHT_P = 10
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  valid_i,
    input  logic [7:0]                            pixel_i,
    input  logic [7:0]                            thresh_i,
    output logic                                  valid_o,
    output logic [7:0]                            data_o,
    output logic                                  eol_o,
    output logic                                  eof_o,
    output logic [$clog2(WIDTH_P*HEIGHT_P+1)-1:0] edge_count_o
);

    // Column counter is at least 3 bits so its low bits double as the bit index.
    localparam int COL_W = (WIDTH_P > 8) ? $clog2(WIDTH_P) : 3;
    localparam int ROW_W = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
    localparam int CNT_W = $clog2(WIDTH_P*HEIGHT_P+1);

    typedef enum logic {
        IDLE_S,
        ACTIVE_S
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [7:0]       shift_byte;
    logic [7:0]       thresh_lat;
    logic [CNT_W-1:0] run_count;

    logic [7:0]       th_use;
    logic [COL_W-1:0] col_use;
    logic [ROW_W-1:0] row_use;
    logic             flag;
    logic [7:0]       byte_next;
    logic             last_col;
    logic             last_row;
    logic             emit;
    logic [CNT_W-1:0] count_next;

    // In IDLE_S the incoming threshold applies to the very pixel that starts the frame.
    always_comb begin
        th_use     = (state == IDLE_S) ? thresh_i : thresh_lat;
        col_use    = (state == IDLE_S) ? '0 : col;
        row_use    = (state == IDLE_S) ? '0 : row;
        flag       = (pixel_i >= th_use);
        byte_next  = shift_byte;
        byte_next[col_use[2:0]] = flag;
        last_col   = (col_use == COL_W'(WIDTH_P - 1));
        last_row   = (row_use == ROW_W'(HEIGHT_P - 1));
        emit       = (col_use[2:0] == 3'd7) || last_col;
        count_next = run_count + CNT_W'(flag);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE_S;
            col          <= '0;
            row          <= '0;
            shift_byte   <= '0;
            thresh_lat   <= '0;
            run_count    <= '0;
            valid_o      <= 1'b0;
            data_o       <= '0;
            eol_o        <= 1'b0;
            eof_o        <= 1'b0;
            edge_count_o <= '0;
        end else begin
            valid_o <= 1'b0;
            eol_o   <= 1'b0;
            eof_o   <= 1'b0;
            if (valid_i) begin
                if (state == IDLE_S) begin
                    thresh_lat <= thresh_i;
                end
                // Clearing the shift byte on every emit keeps rows from sharing a byte.
                if (emit) begin
                    valid_o    <= 1'b1;
                    data_o     <= byte_next;
                    eol_o      <= last_col;
                    eof_o      <= last_col && last_row;
                    shift_byte <= '0;
                end else begin
                    shift_byte <= byte_next;
                end
                if (last_col) begin
                    col <= '0;
                    if (last_row) begin
                        row          <= '0;
                        run_count    <= '0;
                        edge_count_o <= count_next;
                        state        <= IDLE_S;
                    end else begin
                        row       <= row_use + 1'b1;
                        run_count <= count_next;
                        state     <= ACTIVE_S;
                    end
                end else begin
                    col       <= col_use + 1'b1;
                    run_count <= count_next;
                    state     <= ACTIVE_S;
                end
            end
        end
    end

endmodule
